// File: rtl/cd_spi_csr.sv
// SPI mode-0 slave bridging an oversampled SPI link to a 32 x 8-bit CSR bus.
// Optional feature macro: CD_SPI_AUTO_INC_EN (header bit6 enables address auto-increment).
module cd_spi_csr #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_ss_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_prev, ss_prev;
    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_fall;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic [7:0] tx_sr;
    logic       is_write;
    logic       inc_en;
    logic       inc_p1;
    logic       cap_after_inc;
    logic       cap_p2;

    logic       sample_en, hdr_done, byte_done, shift_en, tx_quiet;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ss_prev & ~ss_s;
    assign rx_byte   = {rx_sr, mosi_s};

    assign spi_miso_oe = ~ss_s;

    // Input synchronizers; chip select idles high so its flops reset to 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = HDR;
            HDR:     if (ss_s) state_nxt = IDLE;
                     else if (sclk_rise && bit_cnt == 3'd7) state_nxt = DATA;
            DATA:    if (ss_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sample_en = 1'b0;
        hdr_done  = 1'b0;
        byte_done = 1'b0;
        shift_en  = 1'b0;
        tx_quiet  = 1'b1;
        if (!ss_s) begin
            case (state)
                HDR: begin
                    sample_en = sclk_rise;
                    hdr_done  = sclk_rise && bit_cnt == 3'd7;
                end
                DATA: begin
                    sample_en = sclk_rise;
                    byte_done = sclk_rise && bit_cnt == 3'd7;
                    // bit7 is presented by the capture; shifting starts after the first rising edge
                    shift_en  = !is_write && sclk_fall && bit_cnt != 3'd0;
                    tx_quiet  = is_write;
                end
                default: ;
            endcase
        end
    end

    // Receive path and header decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            is_write <= 1'b0;
            inc_en   <= 1'b0;
        end else begin
            if (state == IDLE)  bit_cnt <= 3'd0;
            else if (sample_en) bit_cnt <= bit_cnt + 3'd1;
            if (sample_en) rx_sr <= rx_byte[6:0];
            if (hdr_done) begin
                is_write <= rx_byte[7];
`ifdef CD_SPI_AUTO_INC_EN
                inc_en   <= rx_byte[6];
`else
                inc_en   <= 1'b0;
`endif
            end
        end
    end

    // Strobe sequencing: strobe cycle, then increment, then (reads) capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_address   <= 5'd0;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_writedata <= 8'd0;
            inc_p1        <= 1'b0;
            cap_after_inc <= 1'b0;
            cap_p2        <= 1'b0;
        end else begin
            csr_read      <= byte_done & ~is_write;
            csr_write     <= byte_done & is_write;
            inc_p1        <= byte_done;
            cap_after_inc <= byte_done & ~is_write;
            cap_p2        <= (inc_p1 & cap_after_inc) | (hdr_done & ~rx_byte[7]);
            if (byte_done && is_write) csr_writedata <= rx_byte;
            if (hdr_done)                csr_address <= rx_byte[4:0];
            else if (inc_p1 && inc_en)   csr_address <= csr_address + 5'd1;
        end
    end

    // Transmit path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sr    <= 8'd0;
            spi_miso <= 1'b0;
        end else if (tx_quiet) begin
            tx_sr    <= 8'd0;
            spi_miso <= 1'b0;
        end else if (cap_p2) begin
            tx_sr    <= csr_readdata;
            spi_miso <= csr_readdata[7];
        end else if (shift_en) begin
            tx_sr    <= {tx_sr[6:0], 1'b0};
            spi_miso <= tx_sr[6];
        end
    end

endmodule

// File: tb/tb_cd_spi_csr.sv
// Scoreboard bench for cd_spi_csr: a bit-banged SPI master plus a CSR bus model.
module tb_cd_spi_csr;

    localparam time HALF = 60ns;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_ss_n, spi_sclk, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [4:0] csr_address;
    logic       csr_read, csr_write;
    logic [7:0] csr_readdata, csr_writedata;

    int errors = 0;
    int checks = 0;

    logic [12:0] wr_q[$];
    logic [7:0]  miso_q[$];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [4:0]  exp_rd_addr = 5'd0;
    logic [7:0]  rd_mem [0:7];
    logic [2:0]  rd_ptr = 3'd0;

    always #5ns clk = ~clk;

    cd_spi_csr #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata)
    );

    // Read data pops one entry per csr_read strobe
    assign csr_readdata = rd_mem[rd_ptr];
    always @(posedge clk) if (reset_n && csr_read) rd_ptr <= rd_ptr + 3'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] e;
        if (reset_n) begin
            if (csr_read || csr_write) check("rw_excl", {31'd0, csr_read & csr_write}, 32'd0);
            if (csr_write) begin
                wr_cnt++;
                if (wr_q.size() == 0) check("wr_unexpected", wr_q.size(), 1);
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", {27'd0, csr_address}, {27'd0, e[12:8]});
                    check("wr_data", {24'd0, csr_writedata}, {24'd0, e[7:0]});
                end
            end
            if (csr_read) begin
                rd_cnt++;
                check("rd_addr", {27'd0, csr_address}, {27'd0, exp_rd_addr});
            end
        end
    end

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            #HALF;
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        spi_ss_n = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        spi_ss_n = 1'b1;
        #(8 * HALF);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_addr"}, {27'd0, csr_address}, 32'd0);
        check({pfx, "_read"}, {31'd0, csr_read}, 32'd0);
        check({pfx, "_write"}, {31'd0, csr_write}, 32'd0);
        check({pfx, "_wdata"}, {24'd0, csr_writedata}, 32'd0);
        check({pfx, "_miso"}, {31'd0, spi_miso}, 32'd0);
        check({pfx, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] exp;
        int         base;

        rd_mem[0] = 8'h11; rd_mem[1] = 8'h22; rd_mem[2] = 8'h33; rd_mem[3] = 8'h44;
        rd_mem[4] = 8'h55; rd_mem[5] = 8'h66; rd_mem[6] = 8'h77; rd_mem[7] = 8'h88;
        reset_n = 1'b0; spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        #23ns;
        check_reset_outputs("rst");
        #20ns reset_n = 1'b1;
        #50ns;

        // Single write: header 0x82, data 0x5A
        wr_q.push_back({5'h02, 8'h5A});
        base = rd_cnt;
        spi_begin();
        spi_byte(8'h82, 8, rx);
        spi_byte(8'h5A, 8, rx);
        check("wr_miso_zero", {24'd0, rx}, 32'd0);
        spi_end();
        check("wr1_drained", wr_q.size(), 0);
        check("wr1_no_read", rd_cnt - base, 0);

        // Read burst: header 0x14, three data bytes
        exp_rd_addr = 5'h14;
        miso_q.push_back(8'h11); miso_q.push_back(8'h22); miso_q.push_back(8'h33);
        base = rd_cnt;
        spi_begin();
        check("rd_oe", {31'd0, spi_miso_oe}, 32'd1);
        spi_byte(8'h14, 8, rx);
        check("rd_hdr_miso", {24'd0, rx}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            spi_byte(8'h00, 8, rx);
            exp = miso_q.pop_front();
            check("rd_miso_byte", {24'd0, rx}, {24'd0, exp});
        end
        spi_end();
        check("rd_pulses", rd_cnt - base, 3);
        check("rd_oe_off", {31'd0, spi_miso_oe}, 32'd0);

        // Burst write from 0x1F: wraps with auto-increment, else stays
        wr_q.push_back({5'h1F, 8'hAA});
`ifdef CD_SPI_AUTO_INC_EN
        wr_q.push_back({5'h00, 8'hBB});
`else
        wr_q.push_back({5'h1F, 8'hBB});
`endif
        spi_begin();
        spi_byte(8'hDF, 8, rx);
        spi_byte(8'hAA, 8, rx);
        spi_byte(8'hBB, 8, rx);
        spi_end();
        check("wrap_drained", wr_q.size(), 0);

        // Abort after 5 bits of a write data byte, then a clean transaction
        base = wr_cnt;
        spi_begin();
        spi_byte(8'h83, 8, rx);
        spi_byte(8'hFF, 5, rx);
        spi_end();
        check("abort_no_wr", wr_cnt - base, 0);
        wr_q.push_back({5'h05, 8'h3C});
        spi_begin();
        spi_byte(8'h85, 8, rx);
        spi_byte(8'h3C, 8, rx);
        spi_end();
        check("post_abort_drained", wr_q.size(), 0);
        check("post_abort_wr", wr_cnt - base, 1);

        // Reset in the middle of a read data byte
        base = rd_cnt;
        spi_begin();
        spi_byte(8'h14, 8, rx);
        spi_byte(8'h00, 4, rx);
        reset_n = 1'b0;
        #1ns;
        check_reset_outputs("midrst");
        spi_ss_n = 1'b1;
        #100ns reset_n = 1'b1;
        #(20 * HALF);
        check("midrst_no_read", rd_cnt - base, 0);
        wr_q.push_back({5'h07, 8'h99});
        spi_begin();
        spi_byte(8'h87, 8, rx);
        spi_byte(8'h99, 8, rx);
        spi_end();
        check("midrst_recover", wr_q.size(), 0);
        check("midrst_no_read2", rd_cnt - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
